// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI serial-SRAM responder: command codes, field widths
// and FSM state encodings.
package spi_mem_pkg;

    localparam int CMD_W  = 8;
    localparam int ADDR_W = 16;

    localparam logic [CMD_W-1:0] CMD_READ  = 8'h03;
    localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_RDATA  = 3'd3;
    localparam state_t ST_WDATA  = 3'd4;
    localparam state_t ST_IGNORE = 3'd5;

    // Unknown opcodes park the frame in IGNORE until chip select rises.
    function automatic state_t cmd_next_state(input logic [CMD_W-1:0] cmd);
        if ((cmd == CMD_READ) || (cmd == CMD_WRITE)) begin
            return ST_ADDR;
        end
        return ST_IGNORE;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with rise/fall pulses taken from
// the synchronized samples.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] warm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
            warm_q <= 2'd0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Edges only count once sync and prev both hold real pin samples, so the
    // reset values never fake an edge (e.g. csb already low at reset release).
    assign q_o    = sync_q;
    assign rise_o = (warm_q == 2'd3) &&  sync_q && !prev_q;
    assign fall_o = (warm_q == 2'd3) && !sync_q &&  prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target emulating a 23LC-style serial SRAM (READ/WRITE, 16-bit address,
// sequential streaming) with a backdoor port for preload and inspection.
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_csb_i,
    input  logic          spi_sclk_i,
    input  logic          spi_mosi_i,
    output logic          spi_miso_o,
    output logic          spi_miso_oe_o,
    input  logic          bd_we_i,
    input  logic [AW-1:0] bd_addr_i,
    input  logic [7:0]    bd_wdata_i,
    output logic [7:0]    bd_rdata_o
);

    logic csb_lvl, csb_rise, csb_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_meta_q, mosi_q;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_csb_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_csb_i),
        .q_o    (csb_lvl),
        .rise_o (csb_rise),
        .fall_o (csb_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_sclk_i),
        .q_o    (sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= spi_mosi_i;
            mosi_q      <= mosi_meta_q;
        end
    end

    logic [7:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    cmd_sr_q, cmd_sr_d;
    logic          is_read_q, is_read_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [6:0]    wr_sr_q, wr_sr_d;
    logic [6:0]    tx_sr_q, tx_sr_d;
    logic          miso_q, miso_d;
    logic [7:0]    spi_rd_q;
    logic [7:0]    bd_rdata_q;
    logic          spi_we;
    logic [7:0]    spi_wdata;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_sr_d  = cmd_sr_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wr_sr_d   = wr_sr_q;
        tx_sr_d   = tx_sr_q;
        miso_d    = miso_q;
        spi_we    = 1'b0;
        spi_wdata = {wr_sr_q, mosi_q};

        if (csb_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A frame opened with sclk high is not mode 0 and would misalign bits.
                    if (csb_fall && !sclk_lvl) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_sr_d  = {cmd_sr_q[5:0], mosi_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(CMD_W - 1)) begin
                            state_d   = cmd_next_state({cmd_sr_q, mosi_q});
                            is_read_d = ({cmd_sr_q, mosi_q} == CMD_READ);
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d    = AW'({addr_q, mosi_q});
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(ADDR_W - 1)) begin
                            state_d   = is_read_q ? ST_RDATA : ST_WDATA;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                ST_RDATA: begin
                    // spi_rd_q tracks mem[addr_q] one clk behind, well ahead of the next fall.
                    if (sclk_fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd0) begin
                            miso_d  = spi_rd_q[7];
                            tx_sr_d = spi_rd_q[6:0];
                        end else begin
                            miso_d  = tx_sr_q[6];
                            tx_sr_d = {tx_sr_q[5:0], 1'b0};
                        end
                        if (bit_cnt_q == 4'd7) begin
                            addr_d    = addr_q + AW'(1);
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        wr_sr_d   = {wr_sr_q[5:0], mosi_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            spi_we    = 1'b1;
                            addr_d    = addr_q + AW'(1);
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end

        if (state_d != ST_RDATA) begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            cmd_sr_q   <= 7'd0;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            wr_sr_q    <= 7'd0;
            tx_sr_q    <= 7'd0;
            miso_q     <= 1'b0;
            spi_rd_q   <= 8'd0;
            bd_rdata_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_sr_q   <= cmd_sr_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            wr_sr_q    <= wr_sr_d;
            tx_sr_q    <= tx_sr_d;
            miso_q     <= miso_d;
            spi_rd_q   <= mem[addr_q];
            bd_rdata_q <= mem[bd_addr_i];
        end
    end

    // Array is deliberately outside reset so preloaded contents survive rst_n.
    always_ff @(posedge clk) begin
        if (spi_we) begin
            mem[addr_q] <= spi_wdata;
        end else if (bd_we_i && csb_lvl) begin
            mem[bd_addr_i] <= bd_wdata_i;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = (state_q == ST_RDATA);
    assign bd_rdata_o    = bd_rdata_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: SPI mode-0 host tasks plus backdoor tasks,
// checked with immediate assertions against hand-computed values.
module tb_spi_mem_responder;
    import spi_mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int CLK_P = 10;
    localparam int HALF  = 40;

    logic          clk;
    logic          rst_n;
    logic          spi_csb;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata;
    logic [7:0]    bd_rdata;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic oe_or, oe_and, miso_or;
    logic [7:0] rx;
    logic [7:0] rd;

    spi_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_csb_i     (spi_csb),
        .spi_sclk_i    (spi_sclk),
        .spi_mosi_i    (spi_mosi),
        .spi_miso_o    (spi_miso),
        .spi_miso_oe_o (spi_miso_oe),
        .bd_we_i       (bd_we),
        .bd_addr_i     (bd_addr),
        .bd_wdata_i    (bd_wdata),
        .bd_rdata_o    (bd_rdata)
    );

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        oe_or   = 1'b0;
        oe_and  = 1'b1;
        miso_or = 1'b0;
    endtask

    // Sends the top nbits of tx; MISO is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            #(HALF);
            rxb[i]  = spi_miso;
            oe_or   = oe_or | spi_miso_oe;
            oe_and  = oe_and & spi_miso_oe;
            miso_or = miso_or | spi_miso;
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
        spi_bits(tx, 8, rxb);
    endtask

    task automatic spi_start();
        spi_csb = 1'b0;
        #(HALF);
    endtask

    task automatic spi_stop();
        #(HALF);
        spi_csb  = 1'b1;
        spi_mosi = 1'b0;
        #(8 * CLK_P);
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        @(negedge clk);
        bd_we    = 1'b0;
    endtask

    task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
        @(negedge clk);
        bd_addr = a;
        @(negedge clk);
        d = bd_rdata;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        spi_csb  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = 8'h00;
        clr_mon();

        // Reset values
        #(3 * CLK_P);
        check8("rst_miso", {7'd0, spi_miso}, 8'h00);
        check8("rst_oe", {7'd0, spi_miso_oe}, 8'h00);
        check8("rst_bd_rdata", bd_rdata, 8'h00);
        check8("rst_state", {5'd0, dut.state_q}, {5'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Backdoor preload then single-byte READ
        bd_write(10'h010, 8'hA5);
        clr_mon();
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        check8("read1_oe_hdr", {7'd0, oe_or}, 8'h00);
        clr_mon();
        spi_byte(8'h00, rx);
        check8("read1_data", rx, 8'hA5);
        check8("read1_oe_data", {7'd0, oe_and}, 8'h01);
        spi_stop();
        check8("read1_oe_after", {7'd0, spi_miso_oe}, 8'h00);

        // Three-byte WRITE at 0x020
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_byte(8'h33, rx);
        spi_stop();
        bd_read(10'h020, rd); check8("wr3_0x20", rd, 8'h11);
        bd_read(10'h021, rd); check8("wr3_0x21", rd, 8'h22);
        bd_read(10'h022, rd); check8("wr3_0x22", rd, 8'h33);

        // Address wrap at top of memory
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hDE, rx);
        spi_byte(8'hAD, rx);
        spi_stop();
        bd_read(10'h3FF, rd); check8("wrap_wr_3ff", rd, 8'hDE);
        bd_read(10'h000, rd); check8("wrap_wr_000", rd, 8'hAD);
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx); check8("wrap_rd_b0", rx, 8'hDE);
        spi_byte(8'h00, rx); check8("wrap_rd_b1", rx, 8'hAD);
        spi_stop();

        // Unknown command 0x05 is ignored
        bd_write(10'h050, 8'h5A);
        clr_mon();
        spi_start();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h50, rx);
        spi_byte(8'hAA, rx);
        spi_stop();
        check8("ign_oe", {7'd0, oe_or}, 8'h00);
        check8("ign_miso", {7'd0, miso_or}, 8'h00);
        bd_read(10'h050, rd); check8("ign_mem", rd, 8'h5A);

        // Backdoor write is blocked while csb is low
        bd_write(10'h060, 8'h12);
        spi_csb = 1'b0;
        repeat (6) @(negedge clk);
        bd_write(10'h060, 8'hEE);
        repeat (2) @(negedge clk);
        spi_csb = 1'b1;
        repeat (6) @(negedge clk);
        bd_read(10'h060, rd); check8("bd_block", rd, 8'h12);

        // Partial second write byte is discarded
        bd_write(10'h031, 8'hC3);
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'h77, rx);
        spi_bits(8'hF0, 4, rx);
        spi_stop();
        bd_read(10'h030, rd); check8("part_0x30", rd, 8'h77);
        bd_read(10'h031, rd); check8("part_0x31", rd, 8'hC3);
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'h00, rx); check8("part_rd_b0", rx, 8'h77);
        spi_byte(8'h00, rx); check8("part_rd_b1", rx, 8'hC3);
        spi_stop();

        // Reset during the address phase of a WRITE
        bd_write(10'h040, 8'h3C);
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h40, 4, rx);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check8("rst_mid_state", {5'd0, dut.state_q}, {5'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_bits(8'h00, 4, rx);
        spi_byte(8'h99, rx);
        spi_stop();
        bd_read(10'h040, rd); check8("rst_mid_mem", rd, 8'h3C);
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h40, rx);
        spi_byte(8'h00, rx); check8("rst_mid_rd", rx, 8'h3C);
        spi_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

Synthesizable SPI memory responder: the target end of the CPU's serial memory port (csb/sclk/mosi/miso). It emulates a 23LC-style serial SRAM with READ/WRITE commands, a 16-bit address and sequential byte streaming. The block is used in simulation benches and on FPGA bring-up boards in place of a physical SRAM. A backdoor port preloads and inspects its contents.

## Interface
- DEPTH, 1024: memory size in bytes; power of two, 2..65536.
- AW, $clog2(DEPTH): internal address width.

Ports:
- clk  input  1  system clock; must run at ≥ 6× the SPI sclk rate.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- spi_csb_i  input  1  chip select, active-low, asynchronous to clk.
- spi_sclk_i  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
- spi_mosi_i  input  1  serial data in, MSB first.
- spi_miso_o  output  1  serial data out, MSB first.
- spi_miso_oe_o  output  1  high while the responder drives MISO (RDATA state only).
- bd_we_i  input  1  backdoor write strobe.
- bd_addr_i  input  AW  backdoor address.
- bd_wdata_i  input  8  backdoor write data.
- bd_rdata_o  output  8  backdoor read data; registered, one cycle after bd_addr_i.

## Operation
- Input path: csb, sclk and mosi each pass through a 2-flop synchronizer. Rising and falling sclk edges are detected from the synchronized samples.
- Frame format: csb falls, then 8-bit command, then 16-bit address MSB first, then data bytes. Only the low AW address bits are used.
- Commands: 0x03 READ, 0x02 WRITE. Any other command enters IGNORE until csb rises.
- FSM states: IDLE, CMD, ADDR, RDATA, WDATA, IGNORE.
  - IDLE → CMD on synced csb fall.
  - CMD → ADDR after 8 rising edges.
  - ADDR → RDATA or WDATA after 16 rising edges.
  - Synced csb high returns to IDLE from any state and clears the bit counter.
- Sampling: MOSI is sampled on rising sclk. MISO updates on falling sclk.
- READ:
  - The byte at addr is fetched between the 24th rising edge and the following falling edge.
  - Bit 7 is driven on that falling edge, then one bit per falling edge.
  - After 8 bits the address increments and the next byte loads seamlessly.
- WRITE: on the 8th rising edge of each data byte, the byte is written to mem[addr] and addr increments.
- Address wrap: addr = (addr+1) mod DEPTH.
- Partial data byte when csb rises: a write byte is discarded; a read byte is simply abandoned.
- MISO is 0 and oe is 0 outside RDATA.
- Backdoor:
  - bd_we_i writes only while synced csb is high. While csb is low the write is ignored.
  - bd reads are always permitted.
- Memory array is not reset. Contents survive rst_n.

## Timing
- Reset values:
  - spi_miso_o=0, spi_miso_oe_o=0, bd_rdata_o=0.
  - FSM=IDLE, counters=0, synchronizers=1 for csb and 0 for sclk/mosi.
- Edge-to-action latency: 3 clk from a pin edge (2 sync + 1 register).
  - This requires sclk high and low phases of ≥ 3 clk each.
  - This requires csb setup/hold to sclk of ≥ 3 clk.
- MISO valid at most 3 clk after a falling sclk edge. The host samples on the next rising edge.
- A memory write commits 3 clk after the 32nd (or 8k+24th) rising edge.
- csb rise mid-frame: IDLE and oe=0 within 3 clk.
- rst_n asserted mid-frame: immediate IDLE. The remainder of the frame is ignored until the next csb fall.

## Structure
- Package spi_mem_pkg holds:
  - CMD_READ=8'h03 and CMD_WRITE=8'h02.
  - The state enum, with widths for the command and address fields (8, 16).
- Sub-module spi_sync_edge: a 2-flop synchronizer with rise/fall pulse outputs, instantiated for sclk and csb. mosi uses a plain synchronizer.
- Memory is an inferred reg array (DEPTH×8) with one write port, arbitrated SPI over backdoor, and registered reads.

## Test plan
- Backdoor write 0xA5 at 0x010, then SPI READ 0x03 0x0010 with 1 byte → MISO returns 0xA5; oe high only during the data phase.
- SPI WRITE 0x02 0x0020 with bytes 0x11,0x22,0x33 → backdoor reads 0x20..0x22 return 0x11,0x22,0x33.
- DEPTH=1024: WRITE at 0x03FF with 0xDE,0xAD → mem[0x3FF]=0xDE and mem[0x000]=0xAD (wrap). READ at 0x03FF for 2 bytes returns 0xDE,0xAD.
- Command 0x05 followed by 24 clocks → MISO stays 0 and oe 0; memory is unchanged.
- WRITE at 0x030 with 0x77 plus 4 bits of a second byte, then csb rises → mem[0x30]=0x77 and mem[0x31] is unchanged. The next READ frame works normally.
- rst_n pulsed during the address phase of a WRITE → no memory write occurs. A backdoor-loaded byte is still readable after reset.
